// File: rtl/arb_requester_if.sv
// Command, arbiter and beat-output signals of one arbitration client.
// The slave modport is the requester's view; master is the environment driving it.
interface arb_requester_if #(
    parameter int DW = 8,
    parameter int LW = 4
);
    logic          cmd_valid;
    logic [DW-1:0] cmd_data;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready;
    logic          req;
    logic          grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          starve;

    modport master (
        output cmd_valid, cmd_data, cmd_len, grant,
        input  cmd_ready, req, out_valid, out_data, out_last, busy, starve
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, grant,
        output cmd_ready, req, out_valid, out_data, out_last, busy, starve
    );
endinterface

// File: rtl/arb_requester.sv
// Arbiter client: queues burst commands and replays each as incrementing beats
// while granted, releasing the arbiter for one cycle between bursts.
module arb_requester #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int LW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rstn,
    arb_requester_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [LW-1:0] len;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    cmd_t          head;
    logic          push;
    logic          pop;

    state_t        state;
    logic [LW-1:0] beat;
    logic [SW-1:0] wait_cnt;

    assign head          = mem[rd_ptr];
    assign bus.cmd_ready = (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == REQ) && bus.grant && (beat == head.len);
    assign bus.busy      = (state != IDLE) || (count != '0);

    // NOTE: storage is not reset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: bus.cmd_data, len: bus.cmd_len};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            beat          <= '0;
            wait_cnt      <= '0;
            bus.req       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.starve    <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state   <= REQ;
                        bus.req <= 1'b1;
                    end
                end
                REQ: begin
                    // A cycle without grant is a preemption: hold req and the beat index.
                    if (bus.grant) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= head.data + DW'(beat);
                        bus.out_last  <= pop;
                        if (pop) begin
                            beat    <= '0;
                            bus.req <= 1'b0;
                            state   <= GAP;
                        end else begin
                            beat <= beat + LW'(1);
                        end
                    end
                end
                GAP: begin
                    if (count != '0) begin
                        state   <= REQ;
                        bus.req <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == REQ && !bus.grant) begin
                if (wait_cnt != SW'(TIMEOUT)) wait_cnt <= wait_cnt + SW'(1);
            end else begin
                wait_cnt <= '0;
            end

            // Sticky until served; a grant takes precedence over a saturated counter.
            if (state == REQ && bus.grant)      bus.starve <= 1'b0;
            else if (wait_cnt == SW'(TIMEOUT)) bus.starve <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// Directed and randomized checks of arb_requester against a transaction
// scoreboard: expected beats are expanded from each accepted command.
module tb_arb_requester;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int LW      = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    arb_requester_if #(.DW(DW), .LW(LW)) bus ();

    arb_requester #(.DW(DW), .DEPTH(DEPTH), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    int          occ   = 0;
    int          beats = 0;
    logic [DW:0] exp_q [$];
    bit          gap_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: snapshot handshakes before the edge, update the model, check #1 after.
    task automatic step();
        logic          pg, pu, rst_edge;
        logic [DW-1:0] d;
        logic [LW-1:0] l;
        int            occ_pre;
        logic [DW:0]   e;
        pg       = bus.req && bus.grant;
        pu       = bus.cmd_valid && bus.cmd_ready;
        d        = bus.cmd_data;
        l        = bus.cmd_len;
        rst_edge = !rstn;
        occ_pre  = occ;
        @(posedge clk);
        #1;
        if (rst_edge) begin
            exp_q.delete();
            occ         = 0;
            gap_pending = 1'b0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_req", bus.req, 0);
            return;
        end
        if (pu) begin
            occ++;
            for (int k = 0; k <= int'(l); k++) begin
                e = {(k == int'(l)), DW'((int'(d) + k) % (1 << DW))};
                exp_q.push_back(e);
            end
        end
        check("out_valid", bus.out_valid, pg);
        if (gap_pending) begin
            check("gap_exit_req", bus.req, occ_pre != 0);
            gap_pending = 1'b0;
        end
        if (bus.out_valid) begin
            beats++;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", bus.out_data, e[DW-1:0]);
                check("out_last", bus.out_last, e[DW]);
                if (e[DW]) begin
                    occ--;
                    check("gap_req", bus.req, 0);
                    gap_pending = 1'b1;
                end
            end
        end
        check("cmd_ready", bus.cmd_ready, occ != DEPTH);
        if (occ != 0) check("busy", bus.busy, 1);
    endtask

    task automatic push_cmd(input logic [DW-1:0] d, input logic [LW-1:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_len   = l;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        for (int n = 0; n < budget && !bus.req; n++) step();
        check("req_timeout", bus.req, 1);
    endtask

    task automatic run_idle(input int budget);
        bus.grant = 1'b1;
        for (int n = 0; n < budget && (bus.busy || exp_q.size() != 0); n++) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [LW-1:0] lens [5];
        bit            pat  [5];
        lens = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd1};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rstn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        bus.grant     = 1'b0;
        step();
        step();
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_starve", bus.starve, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        rstn = 1'b1;

        // Single burst with grant tied high, including push-to-req latency.
        bus.grant = 1'b1;
        push_cmd(8'h10, 4'd2);
        check("t36_req_store", bus.req, 0);
        step();
        check("t36_req_enter", bus.req, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t36_valid", bus.out_valid, 1);
            check("t36_data", bus.out_data, 8'h10 + i);
            check("t36_last", bus.out_last, i == 2);
        end
        check("t36_gap_req", bus.req, 0);
        check("t36_gap_busy", bus.busy, 1);
        step();
        check("t36_idle_req", bus.req, 0);
        check("t36_idle_busy", bus.busy, 0);

        // Data wrap across 2^DW.
        b0 = beats;
        push_cmd(8'hFE, 4'd3);
        run_idle(50);
        check("t37_beats", beats - b0, 4);

        // Preempted burst: beats follow grant, req held throughout.
        bus.grant = 1'b0;
        push_cmd(8'h30, 4'd2);
        wait_req(10);
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            check("t38_req", bus.req, 1);
            bus.grant = pat[i];
            step();
        end
        check("t38_beats", beats - b0, 3);
        check("t38_req_after", bus.req, 0);
        run_idle(20);

        // FIFO fill: fifth command refused, then drained in order.
        bus.grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = DW'(8'h40 + 16 * i);
            bus.cmd_len   = lens[i];
            if (i == 4) check("t39_full", bus.cmd_ready, 0);
            step();
        end
        bus.cmd_valid = 1'b0;
        check("t39_still_full", bus.cmd_ready, 0);
        b0 = beats;
        run_idle(100);
        check("t39_beats", beats - b0, 7);

        // Starvation flag.
        bus.grant = 1'b0;
        push_cmd(8'h55, 4'd0);
        wait_req(10);
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check("t40_no_starve", bus.starve, 0);
        end
        step();
        check("t40_starve_set", bus.starve, 1);
        bus.grant = 1'b1;
        step();
        check("t40_starve_clr", bus.starve, 0);
        run_idle(20);

        // Reset during beat 1 of a burst with two more commands queued.
        bus.grant = 1'b0;
        push_cmd(8'h60, 4'd3);
        push_cmd(8'h70, 4'd1);
        push_cmd(8'h80, 4'd2);
        bus.grant = 1'b1;
        for (int n = 0; n < 10 && !bus.out_valid; n++) step();
        check("t41_beat0", bus.out_data, 8'h60);
        rstn = 1'b0;
        step();
        check("t41_out_data", bus.out_data, 0);
        check("t41_out_last", bus.out_last, 0);
        check("t41_starve", bus.starve, 0);
        check("t41_busy", bus.busy, 0);
        check("t41_cmd_ready", bus.cmd_ready, 1);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t41_no_beat", bus.out_valid, 0);
            check("t41_no_req", bus.req, 0);
        end

        // Randomized traffic with one mid-run reset.
        for (int n = 0; n < 600; n++) begin
            bus.grant     = ($urandom_range(0, 9) < 7);
            bus.cmd_valid = ($urandom_range(0, 2) == 0);
            bus.cmd_data  = DW'($urandom);
            bus.cmd_len   = LW'($urandom_range(0, 3));
            rstn          = (n != 300);
            step();
        end
        bus.cmd_valid = 1'b0;
        rstn          = 1'b1;
        run_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DW, default 8, command/data width.
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of 2).
REQ-003 Parameter LW, default 4, burst-length field width.
REQ-004 Parameter TIMEOUT, default 15, consecutive ungranted request cycles before starve flag.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_data  input  DW  burst base value.
REQ-009 cmd_len  input  LW  burst beats minus one.
REQ-010 cmd_ready  output  1  FIFO can accept (= not full).
REQ-011 req  output  1  request line to the arbiter (registered).
REQ-012 grant  input  1  this client's grant bit from the arbiter.
REQ-013 out_valid  output  1  beat transferred (registered).
REQ-014 out_data  output  DW  beat value (registered).
REQ-015 out_last  output  1  final beat of burst (registered).
REQ-016 busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-017 starve  output  1  sticky starvation flag.

Function
REQ-018 Push SHALL occur on cmd_valid && cmd_ready; {cmd_data, cmd_len} stored in order.
REQ-019 cmd_ready SHALL be low when FIFO holds DEPTH entries, even if a pop occurs that cycle (no push-on-full).
REQ-020 FSM states SHALL be IDLE, REQ, GAP.
REQ-021 IDLE -> REQ when FIFO non-empty; req asserts the cycle REQ is entered; head entry is the active burst.
REQ-022 In REQ, a beat SHALL transfer on every cycle with req && grant; cycles with req && !grant transfer nothing (preemption tolerated, req stays high).
REQ-023 Beat k (k = 0..cmd_len) SHALL carry out_data = cmd_data + k, modulo 2^DW (wrap, no carry out).
REQ-024 out_valid/out_data/out_last SHALL appear one cycle after the transferring req && grant cycle; out_valid low otherwise.
REQ-025 out_last SHALL be high only with beat k = cmd_len; cmd_len = 0 gives a single beat with out_last high.
REQ-026 On the last-beat transfer cycle: FIFO head popped, beat counter cleared, req deasserted next cycle, FSM -> GAP.
REQ-027 GAP SHALL last exactly one cycle with req low (releases arbiter), then -> REQ if FIFO non-empty, else IDLE.
REQ-028 grant while req low (IDLE/GAP) SHALL be ignored: no beat, no state change.
REQ-029 Starve counter SHALL increment each REQ cycle with !grant, clear on any grant cycle or leaving REQ, saturate at TIMEOUT.
REQ-030 starve SHALL set the cycle after the counter reaches TIMEOUT and stay set until the next req && grant cycle, clearing the cycle after it.
REQ-031 Push while FIFO empty and FSM IDLE SHALL yield req high two cycles after the push edge (one to store, one to enter REQ).
REQ-032 Simultaneous push and pop (not full) SHALL keep occupancy unchanged and preserve order.

Reset
REQ-033 rstn low at a rising edge SHALL force: FSM IDLE, FIFO empty, beat and starve counters 0, req/out_valid/out_last/starve/busy 0, out_data 0, cmd_ready 1.
REQ-034 Reset mid-burst SHALL discard the active burst and all queued commands; no further beats after reset.
REQ-035 Reset SHALL have no asynchronous effect; outputs change only on clk edges.

Verification
REQ-036 Single command data=0x10 len=2, grant tied high -> out_data 0x10,0x11,0x12 on consecutive cycles, out_last with 0x12, req low one GAP cycle, then IDLE.
REQ-037 data=0xFE len=3 -> out_data 0xFE,0xFF,0x00,0x01 (wrap), out_last with 0x01.
REQ-038 Grant pattern 1,0,0,1,1 during len=2 burst -> exactly 3 beats, out_valid gaps match grant gaps, req high throughout.
REQ-039 Push 5 commands back-to-back with grant low -> 4 accepted, cmd_ready low on 5th, order preserved when grant later driven high; GAP cycle between each burst.
REQ-040 req high, grant low 15 cycles -> starve rises next cycle; single grant -> starve clears one cycle later.
REQ-041 rstn low during beat 1 of len=3 burst with 2 queued -> all outputs 0, cmd_ready 1, no beats after rstn returns high.
